gigatron_ps2_pad: RTL
=====================

# gigatron_ps2_pad

Converts MiSTer `ps2_key` events into the Gigatron's serial game-controller protocol. It sits directly upstream of `Gigatron_Shell`, emulating the Famicom-style shift register that the shell polls through `famicom_latch`/`famicom_pulse`/`famicom_data`. It keeps a live button image, with key-held semantics, for arrows and face buttons. It also injects typed ASCII characters for a fixed number of controller polls, so BASIC and loaders receive keyboard input.

## Interface
- `HOLD_POLLS`, default 3: number of latch rising edges for which an ASCII code is presented; legal range 1..15.
- `clk_sys` in 1: system clock; all logic runs in this domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_key` in 11: `[10]` toggles once per event, `[9]` pressed (1) / released (0), `[8]` extended (E0) prefix, `[7:0]` set-2 scancode.
- `famicom_latch` in 1: parallel-load strobe from the shell, asynchronous to `clk_sys`.
- `famicom_pulse` in 1: shift clock from the shell, asynchronous to `clk_sys`.
- `famicom_data` out 1: serial controller bit, MSB first, active-low.
- `pad_byte` out 8: byte currently selected for loading (debug/OSD).
- `ascii_active` out 1: high while an ASCII code is being held.

## Operation
- Input sync: `famicom_latch` and `famicom_pulse` each pass through 2 flip-flops, then a third register for edge detection. `ps2_key[10]` is compared with a registered copy, and any difference is one key event.
- Button image `btn_n[7:0]` is active-low and resets to 8'hFF. A press clears the bit and a release sets it.
  - Bit 7 (A) = L-Ctrl 0x14.
  - Bit 6 (B) = L-Alt 0x11.
  - Bit 5 (Select) = Tab 0x0D.
  - Bit 4 (Start) = Esc 0x76.
  - Bit 3 (Up) = E0 0x75.
  - Bit 2 (Down) = E0 0x72.
  - Bit 1 (Left) = E0 0x6B.
  - Bit 0 (Right) = E0 0x74.
  - Extended/non-extended must match exactly: for example, non-extended 0x75 (keypad 8) is not Up.
- Shift state: `shift` is set by press and cleared by release of 0x12 or 0x59. Resets to 0.
- ASCII map applies to non-extended presses only; releases never generate ASCII.
  - Letters a–z produce 0x61–0x7A, or 0x41–0x5A when `shift`=1.
  - Digits 0–9 produce 0x30–0x39, independent of shift.
  - Space 0x29 produces 0x20.
  - Enter 0x5A produces 0x0A.
  - Backspace 0x66 produces 0x7F.
  - All other codes produce no ASCII.
- ASCII FSM:
  - IDLE: `ascii_active`=0, `pad_byte`=`btn_n`. On a mapped press, capture the code, load `hold_cnt`=HOLD_POLLS, and go to HOLD.
  - HOLD: `ascii_active`=1, `pad_byte`=captured code. Each synchronised latch rising edge decrements `hold_cnt`. When `hold_cnt` is 1 at a latch rise, go to IDLE in the next cycle.
  - A new mapped press in HOLD replaces the code, reloads `hold_cnt`, and stays in HOLD.
  - Releasing the typed key does not end HOLD early.
- Shift register `sr[7:0]` resets to 8'hFF.
  - While the synchronised latch is high, `sr` is loaded with `pad_byte` every cycle.
  - On a synchronised pulse rising edge while latch is low, `sr` becomes {sr[6:0],1'b1}.
  - If latch is high, pulse edges are ignored.
  - More than 8 pulses shift in 1s, so `famicom_data`=1.
- `famicom_data` = `sr[7]`.

## Timing
- Reset values: `famicom_data`=1, `pad_byte`=8'hFF, `ascii_active`=0; FSM in IDLE, `hold_cnt`=0, `shift`=0, edge-detect and toggle registers 0.
- Key event to `btn_n`/`pad_byte` update: 2 `clk_sys` cycles after the `ps2_key[10]` edge (1 cycle to register, 1 to update).
- Latch/pulse input edge to `sr` action: 3 `clk_sys` cycles (2 sync cycles + edge detect). `famicom_data` changes in the same cycle as `sr`.
- When a latch rise and a key event occur in the same cycle, the key event wins for the ASCII reload and the decrement is dropped.
- The latch-high load uses the `pad_byte` of the current cycle. A key event during latch-high is visible at the next load cycle.
- Inputs must hold each level for at least 3 `clk_sys` cycles. Shell strobes at 6.25 MHz against a 50 MHz `clk_sys` meet this with margin.
- An asynchronous reset assertion mid-shift or mid-HOLD immediately forces all reset values. No event is replayed after reset.

## Test plan
- Reset: assert `reset_n`=0 mid-HOLD with `sr`=8'h3C. Expect `famicom_data`=1, `pad_byte`=8'hFF, `ascii_active`=0 without waiting for a clock edge.
- Buttons: press E0 0x75 and L-Ctrl, then latch and 8 pulses. Expect `pad_byte`=8'h77 and serial bits 0,1,1,1,0,1,1,1. Release both and expect `pad_byte`=8'hFF.
- Extended discrimination: press non-extended 0x75. Expect `pad_byte` unchanged at 8'hFF and `ascii_active`=0.
- ASCII hold (HOLD_POLLS=3): press L-Shift, then 0x1C ('A'). Expect `pad_byte`=8'h41 for 3 latch cycles, then 8'hFF with `ascii_active`=0.
- Retrigger: during HOLD after 2 polls, press 0x5A. Expect `pad_byte`=8'h0A for a further 3 polls.
- Overshift: latch with `pad_byte`=8'h00, then 10 pulses. Expect 8 zeros, then `famicom_data`=1. Pulses while latch is high leave `sr`=`pad_byte`.

Source files
------------

// File: rtl/gigatron_ps2_pad.sv
// PS/2 key events to Gigatron Famicom-style serial pad: a held button image plus
// typed ASCII codes injected for a fixed number of controller polls.
module gigatron_ps2_pad #(
  parameter int unsigned HOLD_POLLS = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        famicom_latch,
  input  logic        famicom_pulse,
  output logic        famicom_data,
  output logic [7:0]  pad_byte,
  output logic        ascii_active
);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_e;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_POLLS);

  // Set-2 scancode to ASCII; bit 8 flags a mapped key.
  function automatic logic [8:0] ascii_map(input logic [7:0] sc, input logic sh);
    logic [4:0] idx;
    logic       letter;
    logic [8:0] r;
    idx    = '0;
    letter = 1'b1;
    r      = '0;
    case (sc)
      8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;
      8'h23: idx = 5'd3;   8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;
      8'h34: idx = 5'd6;   8'h33: idx = 5'd7;   8'h43: idx = 5'd8;
      8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;
      8'h4D: idx = 5'd15;  8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;
      8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;  8'h3C: idx = 5'd20;
      8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
      default: letter = 1'b0;
    endcase
    if (letter) begin
      r = {1'b1, (sh ? 8'h41 : 8'h61) + {3'b000, idx}};
    end else begin
      case (sc)
        8'h45: r = {1'b1, 8'h30};
        8'h16: r = {1'b1, 8'h31};
        8'h1E: r = {1'b1, 8'h32};
        8'h26: r = {1'b1, 8'h33};
        8'h25: r = {1'b1, 8'h34};
        8'h2E: r = {1'b1, 8'h35};
        8'h36: r = {1'b1, 8'h36};
        8'h3D: r = {1'b1, 8'h37};
        8'h3E: r = {1'b1, 8'h38};
        8'h46: r = {1'b1, 8'h39};
        8'h29: r = {1'b1, 8'h20};
        8'h5A: r = {1'b1, 8'h0A};
        8'h66: r = {1'b1, 8'h7F};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  logic        latch_s1_q, latch_s1_d, latch_s2_q, latch_s2_d, latch_d3_q, latch_d3_d;
  logic        pulse_s1_q, pulse_s1_d, pulse_s2_q, pulse_s2_d, pulse_d3_q, pulse_d3_d;
  logic [10:0] key_q, key_d;
  logic        tog_q, tog_d;
  logic        armed_q, armed_d;
  logic [7:0]  btn_n_q, btn_n_d;
  logic        shift_q, shift_d;
  state_e      state_q, state_d;
  logic [7:0]  code_q, code_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]  sr_q, sr_d;

  logic        latch_rise, pulse_rise;
  logic        key_event, key_press, key_ext;
  logic [7:0]  key_code;
  logic        btn_hit;
  logic [2:0]  btn_idx;
  logic [8:0]  ascii_res;
  logic        mapped_press;

  assign latch_rise = latch_s2_q & ~latch_d3_q;
  assign pulse_rise = pulse_s2_q & ~pulse_d3_q;

  assign key_press = key_q[9];
  assign key_ext   = key_q[8];
  assign key_code  = key_q[7:0];
  assign key_event = armed_q & (key_q[10] ^ tog_q);

  assign ascii_res    = ascii_map(key_code, shift_q);
  assign mapped_press = key_event & key_press & ~key_ext & ascii_res[8];

  assign ascii_active = (state_q == S_HOLD);
  assign pad_byte     = (state_q == S_HOLD) ? code_q : btn_n_q;
  assign famicom_data = sr_q[7];

  // Extended flag must match exactly, so keypad 8 never aliases Up.
  always_comb begin
    btn_hit = 1'b1;
    btn_idx = 3'd0;
    case ({key_ext, key_code})
      {1'b0, 8'h14}: btn_idx = 3'd7;
      {1'b0, 8'h11}: btn_idx = 3'd6;
      {1'b0, 8'h0D}: btn_idx = 3'd5;
      {1'b0, 8'h76}: btn_idx = 3'd4;
      {1'b1, 8'h75}: btn_idx = 3'd3;
      {1'b1, 8'h72}: btn_idx = 3'd2;
      {1'b1, 8'h6B}: btn_idx = 3'd1;
      {1'b1, 8'h74}: btn_idx = 3'd0;
      default:       btn_hit = 1'b0;
    endcase
  end

  // NOTE: every _d starts from its held value so no path through this block infers a latch.
  always_comb begin
    latch_s1_d = famicom_latch;
    latch_s2_d = latch_s1_q;
    latch_d3_d = latch_s2_q;
    pulse_s1_d = famicom_pulse;
    pulse_s2_d = pulse_s1_q;
    pulse_d3_d = pulse_s2_q;

    key_d   = ps2_key;
    armed_d = 1'b1;
    // The first cycle out of reset primes the toggle copy so no stale event replays.
    tog_d   = armed_q ? key_q[10] : ps2_key[10];

    btn_n_d = btn_n_q;
    if (key_event && btn_hit) begin
      btn_n_d[btn_idx] = ~key_press;
    end

    shift_d = shift_q;
    if (key_event && (key_code == 8'h12 || key_code == 8'h59)) begin
      shift_d = key_press;
    end

    state_d    = state_q;
    code_d     = code_q;
    hold_cnt_d = hold_cnt_q;
    if (mapped_press) begin
      // A key event beats a coincident latch rise; that poll is not counted.
      state_d    = S_HOLD;
      code_d     = ascii_res[7:0];
      hold_cnt_d = HOLD_LOAD;
    end else if (state_q == S_HOLD && latch_rise) begin
      if (hold_cnt_q <= 4'd1) begin
        state_d    = S_IDLE;
        hold_cnt_d = 4'd0;
      end else begin
        hold_cnt_d = hold_cnt_q - 4'd1;
      end
    end

    sr_d = sr_q;
    if (latch_s2_q) begin
      sr_d = pad_byte;
    end else if (pulse_rise) begin
      sr_d = {sr_q[6:0], 1'b1};
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      latch_s1_q <= 1'b0;
      latch_s2_q <= 1'b0;
      latch_d3_q <= 1'b0;
      pulse_s1_q <= 1'b0;
      pulse_s2_q <= 1'b0;
      pulse_d3_q <= 1'b0;
      key_q      <= '0;
      tog_q      <= 1'b0;
      armed_q    <= 1'b0;
      btn_n_q    <= 8'hFF;
      shift_q    <= 1'b0;
      state_q    <= S_IDLE;
      code_q     <= 8'h00;
      hold_cnt_q <= 4'd0;
      sr_q       <= 8'hFF;
    end else begin
      latch_s1_q <= latch_s1_d;
      latch_s2_q <= latch_s2_d;
      latch_d3_q <= latch_d3_d;
      pulse_s1_q <= pulse_s1_d;
      pulse_s2_q <= pulse_s2_d;
      pulse_d3_q <= pulse_d3_d;
      key_q      <= key_d;
      tog_q      <= tog_d;
      armed_q    <= armed_d;
      btn_n_q    <= btn_n_d;
      shift_q    <= shift_d;
      state_q    <= state_d;
      code_q     <= code_d;
      hold_cnt_q <= hold_cnt_d;
      sr_q       <= sr_d;
    end
  end

endmodule
